// File: rtl/seg_pkg.sv
`default_nettype none
// ============================================================================
// Package  : seg_pkg
// Brief    : Shared constants, phase encoding and helpers for the seven-segment
//            digit scanning path (scanner + leading-zero mask).
// Revision : 1.0 - initial release
// ============================================================================
package seg_pkg;

  localparam int BCD_W      = 4;
  localparam int BCD_MAX    = 9;
  localparam int MAX_DIGITS = 8;

  // Phase of the current digit slot: guard interval first, then the digit.
  typedef enum logic [0:0] {
    PH_BLANK = 1'b0,
    PH_SHOW  = 1'b1
  } phase_e;

  // One-hot common-pin enable for a digit index.
  function automatic logic [MAX_DIGITS-1:0] onehot_en(input int unsigned idx);
    logic [MAX_DIGITS-1:0] one;
    one = MAX_DIGITS'(1);
    return one << idx;
  endfunction

endpackage
`default_nettype wire

// File: rtl/seg_lz_mask.sv
`default_nettype none
// ============================================================================
// Module   : seg_lz_mask
// Brief    : Combinational leading-zero mask. Bit i is set when suppression is
//            enabled, i > 0 and every digit from i up to the top is zero.
//            Digit 0 is never suppressed so a value of zero still shows "0".
// Revision : 1.0 - initial release
// ============================================================================
module seg_lz_mask
  import seg_pkg::*;
#(
  parameter int NUM_DIGITS = 4
) (
  input  logic [BCD_W*NUM_DIGITS-1:0] digits,
  input  logic                        lz_suppress,
  output logic [NUM_DIGITS-1:0]       suppress
);

  logic w_hi_zero;

  // Walk from the most significant digit down, tracking "all zero so far".
  always_comb begin
    w_hi_zero = 1'b1;
    suppress  = '0;
    for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
      w_hi_zero = w_hi_zero & (digits[i*BCD_W +: BCD_W] == '0);
      if (i > 0) begin
        suppress[i] = lz_suppress & w_hi_zero;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/seg_scan_mux.sv
`default_nettype none
// ============================================================================
// Module   : seg_scan_mux
// Brief    : Time-multiplexed BCD digit scanner feeding the seg10 decoder.
//            Each slot starts with a blanking guard, then drives one digit
//            with a one-hot common-pin enable. The displayed value is swapped
//            only at frame boundaries so the display never tears.
// Revision : 1.0 - initial release
// ============================================================================
module seg_scan_mux
  import seg_pkg::*;
#(
  parameter int NUM_DIGITS   = 4,
  parameter int SCAN_DIV     = 4096,
  parameter int BLANK_CYCLES = 64,
  parameter bit LZ_SUPPRESS  = 1'b1
) (
  input  logic                        clk,
  input  logic                        reset_n,
  input  logic [BCD_W*NUM_DIGITS-1:0] digits,
  input  logic                        upd,
  output logic [BCD_W-1:0]            digit_code,
  output logic [NUM_DIGITS-1:0]       digit_en,
  output logic                        blank,
  output logic                        frame_start
);

  localparam int                 c_t_w      = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int                 c_idx_w    = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam logic [c_t_w-1:0]   c_t_last   = c_t_w'(SCAN_DIV - 1);
  localparam logic [c_idx_w-1:0] c_idx_last = c_idx_w'(NUM_DIGITS - 1);
  // With no guard interval, t=0 is already a SHOW cycle.
  localparam phase_e             c_ph_rst   = (BLANK_CYCLES > 0) ? PH_BLANK : PH_SHOW;

  generate
    if (NUM_DIGITS < 1 || NUM_DIGITS > MAX_DIGITS) begin : g_chk_digits
      $error("seg_scan_mux: NUM_DIGITS out of range 1..8");
    end
    if (BLANK_CYCLES < 0 || SCAN_DIV <= BLANK_CYCLES) begin : g_chk_div
      $error("seg_scan_mux: SCAN_DIV must exceed BLANK_CYCLES >= 0");
    end
  endgenerate

  logic [c_t_w-1:0]            r_t, w_t_nxt;
  logic [c_idx_w-1:0]          r_idx, w_idx_nxt;
  phase_e                      r_phase, w_phase_nxt;
  logic [BCD_W*NUM_DIGITS-1:0] r_active, r_shadow;
  logic                        r_pending;
  logic                        w_t_wrap, w_frame_end;
  logic [NUM_DIGITS-1:0]       w_lz_mask;
  logic [BCD_W-1:0]            w_cur_digit;
  logic                        w_cur_lz, w_cur_sup;
  logic [BCD_W-1:0]            w_code_nxt;
  logic [NUM_DIGITS-1:0]       w_en_nxt;
  logic                        w_blank_nxt;

  assign w_t_wrap    = (r_t == c_t_last);
  assign w_frame_end = w_t_wrap && (r_idx == c_idx_last);

  seg_lz_mask #(
    .NUM_DIGITS (NUM_DIGITS)
  ) u_lz_mask (
    .digits      (r_active),
    .lz_suppress (LZ_SUPPRESS),
    .suppress    (w_lz_mask)
  );

  // Select the active digit and its leading-zero flag for the current slot.
  always_comb begin
    w_cur_digit = '0;
    w_cur_lz    = 1'b0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (r_idx == c_idx_w'(i)) begin
        w_cur_digit = r_active[i*BCD_W +: BCD_W];
        w_cur_lz    = w_lz_mask[i];
      end
    end
    w_cur_sup = (w_cur_digit > BCD_W'(BCD_MAX)) || w_cur_lz;
  end

  // Slot timer, digit index and phase state register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_t     <= '0;
      r_idx   <= '0;
      r_phase <= c_ph_rst;
    end else begin
      r_t     <= w_t_nxt;
      r_idx   <= w_idx_nxt;
      r_phase <= w_phase_nxt;
    end
  end

  // Next timer/index/phase and the slot output decode.
  always_comb begin
    w_t_nxt     = r_t + 1'b1;
    w_idx_nxt   = r_idx;
    w_code_nxt  = '0;
    w_en_nxt    = '0;
    w_blank_nxt = 1'b1;
    if (w_t_wrap) begin
      w_t_nxt   = '0;
      w_idx_nxt = (r_idx == c_idx_last) ? '0 : r_idx + 1'b1;
    end
    w_phase_nxt = (int'(w_t_nxt) < BLANK_CYCLES) ? PH_BLANK : PH_SHOW;
    case (r_phase)
      PH_SHOW: begin
        if (!w_cur_sup) begin
          w_code_nxt  = w_cur_digit;
          w_en_nxt    = NUM_DIGITS'(onehot_en(int'(r_idx)));
          w_blank_nxt = 1'b0;
        end
      end
      default: ;
    endcase
  end

  // Shadow capture on upd; swap into the active set only at the frame end.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_shadow  <= '0;
      r_pending <= 1'b0;
      r_active  <= '0;
    end else begin
      if (upd) begin
        r_shadow  <= digits;
        r_pending <= 1'b1;
      end
      if (w_frame_end && (r_pending || upd)) begin
        r_active  <= upd ? digits : r_shadow;
        r_pending <= 1'b0;
      end
    end
  end

  // Registered outputs, one clock behind the slot state.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      digit_code  <= '0;
      digit_en    <= '0;
      blank       <= 1'b1;
      frame_start <= 1'b0;
    end else begin
      digit_code  <= w_code_nxt;
      digit_en    <= w_en_nxt;
      blank       <= w_blank_nxt;
      frame_start <= (r_t == '0) && (r_idx == '0);
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_seg_scan_mux.sv
`default_nettype none
// ============================================================================
// Module   : tb_seg_scan_mux
// Brief    : Self-checking bench for seg_scan_mux (4 digits, 8 clocks/slot,
//            2 blank clocks). A per-cycle reference model feeds a scoreboard
//            queue; directed checks pin the key edges of each scenario.
// Revision : 1.0 - initial release
// ============================================================================
module tb_seg_scan_mux;

  localparam int N   = 4;
  localparam int DIV = 8;
  localparam int BLK = 2;

  typedef struct packed {
    logic [3:0] code;
    logic [3:0] en;
    logic       blank;
    logic       fs;
  } out_t;

  typedef struct packed {
    out_t a;   // LZ_SUPPRESS=1 instance
    out_t b;   // LZ_SUPPRESS=0 instance
  } pair_t;

  logic        clk     = 1'b0;
  logic        reset_n = 1'b1;
  logic [15:0] digits  = 16'h0000;
  logic        upd     = 1'b0;

  logic [3:0] code_a, en_a, code_b, en_b;
  logic       blank_a, fs_a, blank_b, fs_b;

  int checks   = 0;
  int failures = 0;
  int edge_cnt = 0;

  int         m_t, m_idx;
  logic [3:0] m_act [N];
  logic [15:0] m_shadow;
  bit         m_pend;
  pair_t      sbq[$];

  localparam out_t c_rst = '{code: 4'h0, en: 4'h0, blank: 1'b1, fs: 1'b0};

  seg_scan_mux #(.NUM_DIGITS(N), .SCAN_DIV(DIV), .BLANK_CYCLES(BLK), .LZ_SUPPRESS(1'b1)) u_dut (
    .clk(clk), .reset_n(reset_n), .digits(digits), .upd(upd),
    .digit_code(code_a), .digit_en(en_a), .blank(blank_a), .frame_start(fs_a)
  );

  seg_scan_mux #(.NUM_DIGITS(N), .SCAN_DIV(DIV), .BLANK_CYCLES(BLK), .LZ_SUPPRESS(1'b0)) u_nolz (
    .clk(clk), .reset_n(reset_n), .digits(digits), .upd(upd),
    .digit_code(code_b), .digit_en(en_b), .blank(blank_b), .frame_start(fs_b)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_a(input string tag, input logic [3:0] en, input logic [3:0] code, input logic bl);
    chk({tag, "_en"},    {4'h0, en_a},    {4'h0, en});
    chk({tag, "_code"},  {4'h0, code_a},  {4'h0, code});
    chk({tag, "_blank"}, {7'h0, blank_a}, {7'h0, bl});
  endtask

  task automatic chk_b(input string tag, input logic [3:0] en, input logic [3:0] code, input logic bl);
    chk({tag, "_nolz_en"},    {4'h0, en_b},    {4'h0, en});
    chk({tag, "_nolz_code"},  {4'h0, code_b},  {4'h0, code});
    chk({tag, "_nolz_blank"}, {7'h0, blank_b}, {7'h0, bl});
  endtask

  // Expected outputs produced by the edge that follows the current model state.
  function automatic out_t model_out(input bit lz);
    out_t       o;
    logic [3:0] d;
    bit         sup;
    o    = c_rst;
    o.fs = (m_t == 0) && (m_idx == 0);
    if (m_t >= BLK) begin
      d   = m_act[m_idx];
      sup = 1'b0;
      if (lz && m_idx > 0) begin
        sup = 1'b1;
        for (int j = m_idx; j < N; j++) if (m_act[j] != 4'h0) sup = 1'b0;
      end
      if (d <= 4'd9 && !sup) begin
        o.code  = d;
        o.en    = 4'b0001 << m_idx;
        o.blank = 1'b0;
      end
    end
    return o;
  endfunction

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) edge_cnt <= 0;
    else          edge_cnt <= edge_cnt + 1;
  end

  // Reference model: push the expectation for this edge, then advance.
  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      m_t      <= 0;
      m_idx    <= 0;
      m_pend   <= 1'b0;
      m_shadow <= '0;
      for (int j = 0; j < N; j++) m_act[j] <= 4'h0;
      sbq.delete();
      sbq.push_back('{a: c_rst, b: c_rst});
    end else begin
      sbq.push_back('{a: model_out(1'b1), b: model_out(1'b0)});
      m_t <= (m_t == DIV - 1) ? 0 : m_t + 1;
      if (m_t == DIV - 1) m_idx <= (m_idx == N - 1) ? 0 : m_idx + 1;
      if (upd) begin
        m_shadow <= digits;
        m_pend   <= 1'b1;
      end
      if (m_t == DIV - 1 && m_idx == N - 1 && (m_pend || upd)) begin
        for (int j = 0; j < N; j++) m_act[j] <= upd ? digits[4*j +: 4] : m_shadow[4*j +: 4];
        m_pend <= 1'b0;
      end
    end
  end

  // Scoreboard compare, half a cycle after each edge.
  always @(negedge clk) begin
    pair_t r;
    if (sbq.size() > 0) begin
      r = sbq.pop_front();
      chk("sb_code",    {4'h0, code_a},  {4'h0, r.a.code});
      chk("sb_en",      {4'h0, en_a},    {4'h0, r.a.en});
      chk("sb_blank",   {7'h0, blank_a}, {7'h0, r.a.blank});
      chk("sb_fs",      {7'h0, fs_a},    {7'h0, r.a.fs});
      chk("sb_nolz_code",  {4'h0, code_b},  {4'h0, r.b.code});
      chk("sb_nolz_en",    {4'h0, en_b},    {4'h0, r.b.en});
      chk("sb_nolz_blank", {7'h0, blank_b}, {7'h0, r.b.blank});
    end
  end

  initial begin
    #50000;
    $display("FAIL watchdog expired at edge %0d", edge_cnt);
    $fatal(1, "watchdog");
  end

  task automatic run_to(input int n);
    while (edge_cnt < n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic load(input logic [15:0] v);
    digits = v;
    upd    = 1'b1;
    @(posedge clk);
    #1;
    upd    = 1'b0;
  endtask

  initial begin
    // Asynchronous reset before any clock edge.
    #1 reset_n = 1'b0;
    #1;
    chk_a("rst", 4'h0, 4'h0, 1'b1);
    chk("rst_fs", {7'h0, fs_a}, 8'h00);
    repeat (3) @(posedge clk);
    #2 reset_n = 1'b1;

    // Start-up: guard then digit 0 of the all-zero active set.
    run_to(1);  chk("fs_edge1", {7'h0, fs_a}, 8'h01); chk_a("e1", 4'h0, 4'h0, 1'b1);
    run_to(2);  chk("fs_edge2", {7'h0, fs_a}, 8'h00); chk_a("e2", 4'h0, 4'h0, 1'b1);
    run_to(3);  chk_a("e3", 4'b0001, 4'h0, 1'b0);
    load(16'h4321);

    // Frame 1 shows 4321.
    run_to(33); chk("fs_edge33", {7'h0, fs_a}, 8'h01);
    run_to(35); chk_a("f1_d0", 4'b0001, 4'h1, 1'b0);
    run_to(41); chk_a("f1_s1_guard", 4'h0, 4'h0, 1'b1);
    run_to(43); chk_a("f1_d1", 4'b0010, 4'h2, 1'b0);
    run_to(59); chk_a("f1_d3", 4'b1000, 4'h4, 1'b0);
    run_to(60); load(16'h0070);

    // Frame 2: leading-zero suppression; 1111 queued mid-frame.
    run_to(67); chk_a("lz_d0", 4'b0001, 4'h0, 1'b0);
    run_to(70); load(16'h1111);
    run_to(75); chk_a("lz_d1", 4'b0010, 4'h7, 1'b0);
    run_to(83); chk_a("lz_d2", 4'h0, 4'h0, 1'b1); chk_b("lz_d2", 4'b0100, 4'h0, 1'b0);
    run_to(91); chk_a("lz_d3", 4'h0, 4'h0, 1'b1); chk_b("lz_d3", 4'b1000, 4'h0, 1'b0);

    // Frame 3 shows 1111; 9999 arrives mid-frame and must wait.
    run_to(99);  chk_a("mid_d0", 4'b0001, 4'h1, 1'b0);
    run_to(100); load(16'h9999);
    run_to(126); chk_a("mid_d3", 4'b1000, 4'h1, 1'b0);
    run_to(131); chk_a("mid_next", 4'b0001, 4'h9, 1'b0);

    // Shadow 5555 pending, then upd exactly in the boundary cycle.
    run_to(140); load(16'h5555);
    run_to(159); load(16'h2468);
    run_to(163); chk_a("bnd_d0", 4'b0001, 4'h8, 1'b0);
    run_to(171); chk_a("bnd_d1", 4'b0010, 4'h6, 1'b0);
    run_to(179); chk_a("bnd_d2", 4'b0100, 4'h4, 1'b0);
    run_to(187); chk_a("bnd_d3", 4'b1000, 4'h2, 1'b0);
    run_to(195); chk_a("bnd_hold", 4'b0001, 4'h8, 1'b0);
    run_to(196); load(16'h00A5);

    // Frame 7: invalid BCD in digit 1.
    run_to(227); chk_a("inv_d0", 4'b0001, 4'h5, 1'b0);
    run_to(235); chk_a("inv_d1", 4'h0, 4'h0, 1'b1); chk_b("inv_d1", 4'h0, 4'h0, 1'b1);

    // Reset asserted while digit 2 is being driven.
    run_to(277); chk_b("pre_rst_d2", 4'b0100, 4'h0, 1'b0);
    #1 reset_n = 1'b0;
    #1;
    chk_a("async_rst", 4'h0, 4'h0, 1'b1);
    chk_b("async_rst", 4'h0, 4'h0, 1'b1);
    repeat (2) @(posedge clk);
    #2 reset_n = 1'b1;
    run_to(1);  chk("fs_restart", {7'h0, fs_a}, 8'h01);
    run_to(3);  chk_a("restart_d0", 4'b0001, 4'h0, 1'b0);
    run_to(11); chk_a("restart_d1", 4'h0, 4'h0, 1'b1); chk_b("restart_d1", 4'b0010, 4'h0, 1'b0);
    run_to(20);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
